// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//   MEM-stage load/store engine. Takes the registered MEM-stage control and
//   operands from ex_mem_register and issues one data-memory transaction per
//   load or store. Store data is lane-replicated with matching byte enables.
//   Load data is sign- or zero-extended. stall_mem holds EX/MEM and the
//   upstream stages until the access completes.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   mem_do_read_ctrl_mem    load present in MEM
//   mem_do_write_ctrl_mem   store present in MEM (wins over read)
//   mem_ctrl_mem[2:0]       size/sign: B=0 H=1 W=2 BU=4 HU=5
//   alu_result_mem[31:0]    effective byte address
//   mem_data_in_mem[31:0]   right-justified store data
//   dmem_req/we/addr/be/wdata   request channel to data memory
//   dmem_ready              memory accepts the request this cycle
//   dmem_rvalid/rdata       read response channel
//   load_data_mem[31:0]     extended load result
//   stall_mem               pipeline hold while an access is in flight
//   misaligned_mem          alignment exception (combinational pulse)
//   bus_err_mem             timeout exception (one-cycle pulse)
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_do_read_ctrl_mem,
    input  logic        mem_do_write_ctrl_mem,
    input  logic [2:0]  mem_ctrl_mem,
    input  logic [31:0] alu_result_mem,
    input  logic [31:0] mem_data_in_mem,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] load_data_mem,
    output logic        stall_mem,
    output logic        misaligned_mem,
    output logic        bus_err_mem
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_DONE
    } state_t;

    state_t             r_state;
    logic               r_req;
    logic               r_we;
    logic [3:0]         r_be;
    logic [31:0]        r_load;
    logic               r_bus_err;
    logic [CNT_W-1:0]   r_cnt;
    logic [29:0]        r_addr_hi;
    logic [1:0]         r_off;
    logic [2:0]         r_ctrl;
    logic [31:0]        r_wdata;

    logic               w_op_wr;
    logic               w_op_rd;
    logic               w_op;
    logic               w_aligned;
    logic               w_start;
    logic               w_cnt_last;

    // Byte enables for the access size, shifted to the addressed lane.
    function automatic logic [3:0] f_lane_be(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data replicated across all lanes; byte enables pick the live one.
    function automatic logic [31:0] f_lane_wdata(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] wd;
        case (size)
            2'b00:   wd = {4{d[7:0]}};
            2'b01:   wd = {2{d[15:0]}};
            default: wd = d;
        endcase
        return wd;
    endfunction

    // Select the addressed byte/half from the read word and extend it.
    function automatic logic [31:0] f_load_ext(input logic [2:0] op, input logic [1:0] off,
                                               input logic [31:0] rdata);
        logic [31:0] sh_b;
        logic [31:0] sh_h;
        logic [31:0] res;
        sh_b = rdata >> {off, 3'b000};
        sh_h = rdata >> {off[1], 4'b0000};
        case (op)
            3'b000:  res = {{24{sh_b[7]}}, sh_b[7:0]};
            3'b001:  res = {{16{sh_h[15]}}, sh_h[15:0]};
            3'b100:  res = {24'h000000, sh_b[7:0]};
            3'b101:  res = {16'h0000, sh_h[15:0]};
            default: res = rdata;
        endcase
        return res;
    endfunction

    // Write wins when both strobes are high.
    assign w_op_wr = mem_do_write_ctrl_mem;
    assign w_op_rd = mem_do_read_ctrl_mem & ~mem_do_write_ctrl_mem;
    assign w_op    = w_op_wr | w_op_rd;

    always_comb begin
        w_aligned = 1'b1;
        case (mem_ctrl_mem[1:0])
            2'b00:   w_aligned = 1'b1;
            2'b01:   w_aligned = ~alu_result_mem[0];
            default: w_aligned = (alu_result_mem[1:0] == 2'b00);
        endcase
    end

    assign w_start        = (r_state == S_IDLE) && w_op && w_aligned;
    assign misaligned_mem = (r_state == S_IDLE) && w_op && !w_aligned;
    assign stall_mem      = w_start || (r_state == S_REQ) || (r_state == S_RESP);
    assign w_cnt_last     = (r_cnt == CNT_W'(MAX_WAIT - 1));

    // Address/data snapshot taken as the access starts, so the request stays
    // stable through REQ regardless of what the upstream stage presents.
    always_ff @(posedge clk) begin
        if (w_start) begin
            r_addr_hi <= alu_result_mem[31:2];
            r_off     <= alu_result_mem[1:0];
            r_ctrl    <= mem_ctrl_mem;
            r_wdata   <= f_lane_wdata(mem_ctrl_mem[1:0], mem_data_in_mem);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_be      <= 4'b0000;
            r_load    <= 32'h0;
            r_bus_err <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_bus_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_REQ;
                        r_req   <= 1'b1;
                        r_we    <= w_op_wr;
                        r_be    <= f_lane_be(mem_ctrl_mem[1:0], alu_result_mem[1:0]);
                        r_cnt   <= '0;
                    end
                end
                S_REQ: begin
                    // A completing handshake takes priority over the timeout.
                    if (dmem_ready) begin
                        r_req   <= 1'b0;
                        r_state <= r_we ? S_DONE : S_RESP;
                        r_cnt   <= r_cnt + 1'b1;
                    end else if (w_cnt_last) begin
                        r_req     <= 1'b0;
                        r_bus_err <= 1'b1;
                        r_load    <= 32'h0;
                        r_state   <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (dmem_rvalid) begin
                        r_load  <= f_load_ext(r_ctrl, r_off, dmem_rdata);
                        r_state <= S_DONE;
                    end else if (w_cnt_last) begin
                        r_bus_err <= 1'b1;
                        r_load    <= 32'h0;
                        r_state   <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                // The instruction advances on this edge; never reissue a held op.
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign dmem_req      = r_req;
    assign dmem_we       = r_we;
    assign dmem_be       = r_be;
    assign dmem_addr     = {r_addr_hi, 2'b00};
    assign dmem_wdata    = r_wdata;
    assign load_data_mem = r_load;
    assign bus_err_mem   = r_bus_err;

endmodule
